// File: rtl/data_bus_pkg.sv
// Shared encodings for the data bus responder: access sizes, FSM states and wait-counter width.
package data_bus_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_DONE
   } state_e;

endpackage

// File: rtl/data_bus_lane_align.sv
// Byte-lane steering for the data RAM: byte enables, store-data replication, load right-align/zero-extend.
// Purely combinational; illegal sizes never reach an access, so they produce no enables.
module data_bus_lane_align
   import data_bus_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wlane_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      rbyte   = rword_i[{lo_i, 3'b000} +: 8];
      rhalf   = lo_i[1] ? rword_i[31:16] : rword_i[15:0];
      be_o    = 4'b0000;
      wlane_o = wdata_i;
      rdata_o = rword_i;
      case (size_i)
         SIZE_BYTE: begin
            be_o    = 4'b0001 << lo_i;
            wlane_o = {4{wdata_i[7:0]}};
            rdata_o = {24'h0, rbyte};
         end
         SIZE_HALF: begin
            be_o    = lo_i[1] ? 4'b1100 : 4'b0011;
            wlane_o = {2{wdata_i[15:0]}};
            rdata_o = {16'h0, rhalf};
         end
         SIZE_WORD: be_o = 4'b1111;
         default: ;
      endcase
   end

endmodule

// File: rtl/data_bus_responder.sv
// Data bus responder: one address window onto a word RAM, with wait states and fault reporting.
// Optional DATA_BUS_CLEAR_ON_RESET_EN zeroes the RAM one word per cycle after reset release.
module data_bus_responder
   import data_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
   parameter int          DATA_ADDR_WIDTH = 10,
   parameter int          WAIT_STATES     = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rd_i,
   input  logic        wd_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_in_i,
   output logic [31:0] data_out_o,
   output logic        ready_o,
   output logic        busy_o,
   output logic        fault_o
);

   localparam int          DEPTH        = 2**DATA_ADDR_WIDTH;
   localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH);

   state_e                     state_q;
   logic                       ready_q, fault_q, op_rd_q;
   logic [31:0]                dout_q, wdata_q;
   logic [1:0]                 size_q, lo_q;
   logic [DATA_ADDR_WIDTH-1:0] idx_q;
   logic [WAIT_CNT_W-1:0]      wcnt_q;
`ifdef DATA_BUS_CLEAR_ON_RESET_EN
   logic [DATA_ADDR_WIDTH-1:0] init_q;
`endif

   logic [31:0] mem [DEPTH];
   logic [31:0] req_off, wlane, rdata;
   logic [3:0]  be;
   logic        req_err;

   // Offset below BASE_ADDR wraps to a huge value, so the low-bound test is kept explicit.
   always_comb begin
      req_off = addr_i - BASE_ADDR;
      req_err = (rd_i && wd_i) || (size_i == SIZE_ILL) || (addr_i < BASE_ADDR) ||
                (req_off >= WINDOW_BYTES) ||
                (size_i == SIZE_HALF && addr_i[0]) ||
                (size_i == SIZE_WORD && addr_i[1:0] != 2'b00);
   end

   data_bus_lane_align u_align (
      .size_i  (size_q),
      .lo_i    (lo_q),
      .wdata_i (wdata_q),
      .rword_i (mem[idx_q]),
      .be_o    (be),
      .wlane_o (wlane),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
`ifdef DATA_BUS_CLEAR_ON_RESET_EN
         state_q <= ST_INIT;
         init_q  <= '0;
`else
         state_q <= ST_IDLE;
`endif
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         dout_q  <= '0;
         op_rd_q <= 1'b0;
         wdata_q <= '0;
         size_q  <= SIZE_BYTE;
         lo_q    <= 2'b00;
         idx_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         fault_q <= 1'b0;
         case (state_q)
`ifdef DATA_BUS_CLEAR_ON_RESET_EN
            ST_INIT: begin
               init_q <= init_q + 1'b1;
               if (&init_q) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
`endif
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (ready_q && (rd_i || wd_i)) begin
                  op_rd_q <= rd_i;
                  wdata_q <= data_in_i;
                  size_q  <= size_i;
                  lo_q    <= addr_i[1:0];
                  idx_q   <= req_off[DATA_ADDR_WIDTH+1:2];
                  if (req_err) begin
                     state_q <= ST_DONE;
                     fault_q <= 1'b1;
                     dout_q  <= '0;
                  end else if (WAIT_STATES > 0) begin
                     state_q <= ST_WAIT;
                     wcnt_q  <= WAIT_CNT_W'(WAIT_STATES - 1);
                  end else begin
                     state_q <= ST_ACCESS;
                  end
               end
            end
            ST_WAIT: begin
               if (wcnt_q == '0) state_q <= ST_ACCESS;
               else              wcnt_q  <= wcnt_q - 1'b1;
            end
            ST_ACCESS: begin
               if (op_rd_q) dout_q <= rdata;
               state_q <= ST_DONE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // RAM is only touched on an ACCESS edge (or INIT), so an async reset mid-request never writes.
   logic                       mem_we;
   logic [3:0]                 mem_be;
   logic [DATA_ADDR_WIDTH-1:0] mem_idx;
   logic [31:0]                mem_wdat;

   always_comb begin
      mem_we   = (state_q == ST_ACCESS) && !op_rd_q;
      mem_be   = be;
      mem_idx  = idx_q;
      mem_wdat = wlane;
`ifdef DATA_BUS_CLEAR_ON_RESET_EN
      if (state_q == ST_INIT && rst_i) begin
         mem_we   = 1'b1;
         mem_be   = 4'b1111;
         mem_idx  = init_q;
         mem_wdat = '0;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
         end
      end
   end

   always_comb begin
      busy_o = (state_q == ST_IDLE && ready_q && (rd_i || wd_i)) ||
               state_q == ST_WAIT || state_q == ST_ACCESS;
`ifdef DATA_BUS_CLEAR_ON_RESET_EN
      busy_o = busy_o || (state_q == ST_INIT && rst_i);
`endif
   end

   assign data_out_o = dout_q;
   assign ready_o    = ready_q;
   assign fault_o    = fault_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder in its default build (BASE 0x1000, 1024 words, one wait state).
module tb_data_bus_responder;

   localparam int WS = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd = 1'b0, wd = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0, din = '0;
   logic [31:0] dout;
   logic        ready, busy, fault;

   int checks = 0;
   int errors = 0;

   int          nb;
   logic [31:0] od;
   logic        of;

   always #5 clk = ~clk;

   data_bus_responder #(
      .BASE_ADDR       (32'h0000_1000),
      .DATA_ADDR_WIDTH (10),
      .WAIT_STATES     (WS)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .rd_i       (rd),
      .wd_i       (wd),
      .size_i     (size),
      .addr_i     (addr),
      .data_in_i  (din),
      .data_out_o (dout),
      .ready_o    (ready),
      .busy_o     (busy),
      .fault_o    (fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one request from an IDLE-cycle negedge; returns busy cycles after the request
   // cycle and the DONE-cycle data/fault, ending on the following negedge.
   task automatic req(input logic r, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d, input bit hold,
                      output int nbusy, output logic [31:0] odat, output logic ofault);
      bit done;
      rd = r; wd = w; size = sz; addr = a; din = d;
      #1;
      chk("req_cycle_busy", {31'b0, busy}, 32'd1);
      nbusy = 0;
      done  = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy) nbusy++;
         else      done = 1'b1;
      end
      chk("req_timeout", {31'b0, done}, 32'd1);
      odat   = dout;
      ofault = fault;
      if (!hold) begin
         rd = 1'b0;
         wd = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst = 1'b0;
      rd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_busy_gated", {31'b0, busy}, 32'd0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      chk("rst_dout", dout, 32'h0);
      rd  = 1'b0;
      rst = 1'b1;
      #1;
      chk("release_ready_low", {31'b0, ready}, 32'd0);
      @(negedge clk);
      chk("first_cycle_ready", {31'b0, ready}, 32'd1);

      req(1'b0, 1'b1, 2'b10, 32'h1004, 32'hDEAD_BEEF, 1'b0, nb, od, of);
      chk("wr_word_busy", nb, WS + 1);
      chk("wr_word_fault", {31'b0, of}, 32'd0);
      req(1'b1, 1'b0, 2'b10, 32'h1004, 32'h0, 1'b0, nb, od, of);
      chk("rd_word_data", od, 32'hDEAD_BEEF);
      chk("rd_word_busy", nb, WS + 1);

      req(1'b0, 1'b1, 2'b00, 32'h1006, 32'h0000_00A5, 1'b0, nb, od, of);
      chk("wr_byte_busy", nb, WS + 1);
      req(1'b1, 1'b0, 2'b10, 32'h1004, 32'h0, 1'b0, nb, od, of);
      chk("rd_word_after_byte", od, 32'hDEA5_BEEF);
      req(1'b1, 1'b0, 2'b00, 32'h1006, 32'h0, 1'b0, nb, od, of);
      chk("rd_byte", od, 32'h0000_00A5);
      req(1'b1, 1'b0, 2'b00, 32'h1005, 32'h0, 1'b0, nb, od, of);
      chk("rd_byte_lane1", od, 32'h0000_00BE);
      req(1'b1, 1'b0, 2'b01, 32'h1006, 32'h0, 1'b0, nb, od, of);
      chk("rd_half_hi", od, 32'h0000_DEA5);
      req(1'b0, 1'b1, 2'b01, 32'h1004, 32'h0000_1357, 1'b0, nb, od, of);
      req(1'b1, 1'b0, 2'b10, 32'h1004, 32'h0, 1'b0, nb, od, of);
      chk("wr_half_lo", od, 32'hDEA5_1357);

      req(1'b1, 1'b0, 2'b01, 32'h1003, 32'h0, 1'b0, nb, od, of);
      chk("misalign_half_fault", {31'b0, of}, 32'd1);
      chk("misalign_half_dout", od, 32'h0);
      chk("misalign_half_busy", nb, 32'd0);
      chk("fault_pulse_ends", {31'b0, fault}, 32'd0);
      req(1'b0, 1'b1, 2'b11, 32'h1004, 32'hFFFF_FFFF, 1'b0, nb, od, of);
      chk("size11_fault", {31'b0, of}, 32'd1);
      req(1'b1, 1'b1, 2'b10, 32'h1004, 32'h0000_0000, 1'b0, nb, od, of);
      chk("rdwd_fault", {31'b0, of}, 32'd1);
      chk("rdwd_dout", od, 32'h0);
      req(1'b0, 1'b1, 2'b10, 32'h1006, 32'h0000_0000, 1'b0, nb, od, of);
      chk("misalign_word_fault", {31'b0, of}, 32'd1);
      req(1'b1, 1'b0, 2'b10, 32'h1004, 32'h0, 1'b0, nb, od, of);
      chk("word_unchanged", od, 32'hDEA5_1357);

      req(1'b0, 1'b1, 2'b10, 32'h1000, 32'h0BAD_C0DE, 1'b0, nb, od, of);
      req(1'b0, 1'b1, 2'b10, 32'h1FFC, 32'hCAFE_F00D, 1'b0, nb, od, of);
      chk("top_word_fault", {31'b0, of}, 32'd0);
      chk("top_word_busy", nb, WS + 1);
      req(1'b0, 1'b1, 2'b10, 32'h0FFC, 32'h1111_1111, 1'b0, nb, od, of);
      chk("below_window_fault", {31'b0, of}, 32'd1);
      req(1'b0, 1'b1, 2'b10, 32'h2000, 32'h2222_2222, 1'b0, nb, od, of);
      chk("above_window_fault", {31'b0, of}, 32'd1);
      req(1'b1, 1'b0, 2'b10, 32'h1FFC, 32'h0, 1'b0, nb, od, of);
      chk("top_word_kept", od, 32'hCAFE_F00D);
      req(1'b1, 1'b0, 2'b10, 32'h1000, 32'h0, 1'b0, nb, od, of);
      chk("base_word_kept", od, 32'h0BAD_C0DE);

      req(1'b1, 1'b0, 2'b10, 32'h1FFC, 32'h0, 1'b1, nb, od, of);
      chk("b2b_idle_busy", {31'b0, busy}, 32'd1);
      req(1'b1, 1'b0, 2'b10, 32'h1000, 32'h0, 1'b0, nb, od, of);
      chk("b2b_second_data", od, 32'h0BAD_C0DE);
      chk("b2b_second_busy", nb, WS + 1);

      req(1'b0, 1'b1, 2'b10, 32'h1008, 32'h5A5A_5A5A, 1'b0, nb, od, of);
      rd = 1'b0; wd = 1'b1; size = 2'b10; addr = 32'h1008; din = 32'h0000_1234;
      @(posedge clk);
      @(negedge clk);
      chk("rst_wait_busy_before", {31'b0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_wait_busy", {31'b0, busy}, 32'd0);
      chk("rst_wait_ready", {31'b0, ready}, 32'd0);
      wd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_wait_ready_back", {31'b0, ready}, 32'd1);
      req(1'b1, 1'b0, 2'b10, 32'h1008, 32'h0, 1'b0, nb, od, of);
      chk("rst_wait_no_write", od, 32'h5A5A_5A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
